// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-Lite response codes and read-slave state type
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RVALID
    } rd_state_t;

endpackage

// File: rtl/axi4lite_read_if.sv
// rtl/axi4lite_read_if.sv - AXI4-Lite AR and R channel bundle
interface axi4lite_read_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport slave (
        input  axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axi4lite_read.sv
// rtl/axi4lite_read.sv - AXI4-Lite read slave bridging to a strobe/ack fabric register port
module axi4lite_read
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 40,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    axi4lite_read_if.slave        axi,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [2:0]            rd_prot,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ack,
    input  logic                  rd_err
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    rd_state_t             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic                  req_q, req_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            prot_q    <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            req_q     <= req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        req_d     = 1'b0;

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (axi.axi_arvalid && arready_q) begin
                    addr_d    = axi.axi_araddr;
                    prot_d    = axi.axi_arprot;
                    req_d     = 1'b1;
                    arready_d = 1'b0;
                    timer_d   = '0;
                    state_d   = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // Ack is checked before the timeout so a last-cycle ack still returns data.
                if (rd_ack) begin
                    rdata_d  = rd_data;
                    rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = RVALID;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                    state_d  = RVALID;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RVALID: begin
                if (axi.axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;
    assign rd_addr         = addr_q;
    assign rd_prot         = prot_q;
    assign rd_req          = req_q;

endmodule

// File: tb/tb_axi4lite_read.sv
// tb/tb_axi4lite_read.sv - directed self-checking bench for axi4lite_read
module tb_axi4lite_read;

    localparam int AW = 40;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_prot;
    logic          rd_req;
    logic [DW-1:0] rd_data = '0;
    logic          rd_ack = 1'b0;
    logic          rd_err = 1'b0;

    int total = 0;
    int bad   = 0;

    axi4lite_read_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4lite_read #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .axi(axi.slave),
        .rd_addr(rd_addr),
        .rd_prot(rd_prot),
        .rd_req(rd_req),
        .rd_data(rd_data),
        .rd_ack(rd_ack),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ar(input logic [AW-1:0] a, input logic [2:0] p);
        axi.axi_araddr  = a;
        axi.axi_arprot  = p;
        axi.axi_arvalid = 1'b1;
        tick();
        axi.axi_arvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (axi.axi_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", axi.axi_arready); end
        total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", axi.axi_rvalid); end
        total++; if (axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b exp=00", axi.axi_rresp); end
        total++; if (axi.axi_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", axi.axi_rdata); end
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL rst_rd_req got=%b exp=0", rd_req); end
        total++; if (rd_addr !== 40'h0) begin bad++; $display("FAIL rst_rd_addr got=%h exp=0", rd_addr); end
        total++; if (rd_prot !== 3'b000) begin bad++; $display("FAIL rst_rd_prot got=%b exp=0", rd_prot); end
        reset = 1'b0;
        tick();
        total++; if (axi.axi_arready !== 1'b1) begin bad++; $display("FAIL rst_release_arready got=%b exp=1", axi.axi_arready); end
    endtask

    task automatic test_zero_latency();
        start_ar(40'h00_A000_0010, 3'b010);
        total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL zl_rd_req got=%b exp=1", rd_req); end
        total++; if (rd_addr !== 40'h00_A000_0010) begin bad++; $display("FAIL zl_rd_addr got=%h exp=00a0000010", rd_addr); end
        total++; if (rd_prot !== 3'b010) begin bad++; $display("FAIL zl_rd_prot got=%b exp=010", rd_prot); end
        total++; if (axi.axi_arready !== 1'b0) begin bad++; $display("FAIL zl_arready_busy got=%b exp=0", axi.axi_arready); end
        rd_ack = 1'b1; rd_data = 32'h1234_5678; rd_err = 1'b0;
        tick();
        rd_ack = 1'b0;
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL zl_rd_req_pulse got=%b exp=0", rd_req); end
        total++; if (axi.axi_rvalid !== 1'b1) begin bad++; $display("FAIL zl_rvalid got=%b exp=1", axi.axi_rvalid); end
        total++; if (axi.axi_rdata !== 32'h1234_5678) begin bad++; $display("FAIL zl_rdata got=%h exp=12345678", axi.axi_rdata); end
        total++; if (axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL zl_rresp got=%b exp=00", axi.axi_rresp); end
        tick();
        total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL zl_rvalid_drop got=%b exp=0", axi.axi_rvalid); end
        total++; if (axi.axi_arready !== 1'b1) begin bad++; $display("FAIL zl_arready_back got=%b exp=1", axi.axi_arready); end
    endtask

    task automatic test_slverr();
        start_ar(40'h12_3456_7890, 3'b001);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (rd_addr !== 40'h12_3456_7890) begin bad++; $display("FAIL se_rd_addr_stable got=%h exp=1234567890", rd_addr); end
            total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL se_rvalid_early got=%b exp=0", axi.axi_rvalid); end
        end
        rd_ack = 1'b1; rd_err = 1'b1; rd_data = 32'hDEAD_BEEF;
        tick();
        rd_ack = 1'b0; rd_err = 1'b0;
        total++; if (axi.axi_rvalid !== 1'b1) begin bad++; $display("FAIL se_rvalid got=%b exp=1", axi.axi_rvalid); end
        total++; if (axi.axi_rresp !== 2'b10) begin bad++; $display("FAIL se_rresp got=%b exp=10", axi.axi_rresp); end
        total++; if (axi.axi_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL se_rdata got=%h exp=deadbeef", axi.axi_rdata); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        start_ar(40'h00_0000_0100, 3'b000);
        n = 0;
        while (axi.axi_rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++; if (n !== 8) begin bad++; $display("FAIL to_latency got=%0d exp=8", n); end
        total++; if (axi.axi_rresp !== 2'b10) begin bad++; $display("FAIL to_rresp got=%b exp=10", axi.axi_rresp); end
        total++; if (axi.axi_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", axi.axi_rdata); end
        tick();
        rd_ack = 1'b1; rd_data = 32'hFFFF_FFFF;
        tick();
        rd_ack = 1'b0;
        total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL to_late_ack_rvalid got=%b exp=0", axi.axi_rvalid); end
        total++; if (axi.axi_arready !== 1'b1) begin bad++; $display("FAIL to_late_ack_arready got=%b exp=1", axi.axi_arready); end
        start_ar(40'h00_0000_0200, 3'b000);
        rd_ack = 1'b1; rd_data = 32'h0BAD_C0DE;
        tick();
        rd_ack = 1'b0;
        total++; if (axi.axi_rvalid !== 1'b1 || axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL to_next_read got=%b/%b exp=1/00", axi.axi_rvalid, axi.axi_rresp); end
        total++; if (axi.axi_rdata !== 32'h0BAD_C0DE) begin bad++; $display("FAIL to_next_rdata got=%h exp=0badc0de", axi.axi_rdata); end
        tick();
    endtask

    task automatic test_hold();
        axi.axi_rready = 1'b0;
        start_ar(40'h00_0000_0A00, 3'b000);
        rd_ack = 1'b1; rd_data = 32'h55AA_33CC;
        tick();
        rd_ack = 1'b0;
        axi.axi_araddr = 40'h00_0000_0B00;
        axi.axi_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++; if (axi.axi_rvalid !== 1'b1) begin bad++; $display("FAIL hd_rvalid got=%b exp=1", axi.axi_rvalid); end
            total++; if (axi.axi_rdata !== 32'h55AA_33CC) begin bad++; $display("FAIL hd_rdata got=%h exp=55aa33cc", axi.axi_rdata); end
            total++; if (axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL hd_rresp got=%b exp=00", axi.axi_rresp); end
            total++; if (axi.axi_arready !== 1'b0) begin bad++; $display("FAIL hd_arready got=%b exp=0", axi.axi_arready); end
            total++; if (rd_addr !== 40'h00_0000_0A00) begin bad++; $display("FAIL hd_rd_addr got=%h exp=a00", rd_addr); end
            tick();
        end
        axi.axi_rready = 1'b1;
        tick();
        total++; if (axi.axi_rvalid !== 1'b0 || axi.axi_arready !== 1'b1) begin bad++; $display("FAIL hd_release got=%b/%b exp=0/1", axi.axi_rvalid, axi.axi_arready); end
        total++; if (rd_addr !== 40'h00_0000_0A00) begin bad++; $display("FAIL hd_addr_not_yet got=%h exp=a00", rd_addr); end
        tick();
        axi.axi_arvalid = 1'b0;
        total++; if (rd_req !== 1'b1 || rd_addr !== 40'h00_0000_0B00) begin bad++; $display("FAIL hd_new_addr got=%b/%h exp=1/b00", rd_req, rd_addr); end
        rd_ack = 1'b1; rd_data = 32'h0000_0B0B;
        tick();
        rd_ack = 1'b0;
        total++; if (axi.axi_rdata !== 32'h0000_0B0B) begin bad++; $display("FAIL hd_new_rdata got=%h exp=00000b0b", axi.axi_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_ar(40'h00_0000_0C00, 3'b111);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_ack = 1'b1; rd_data = 32'hAAAA_5555;
        total++; if (axi.axi_arready !== 1'b0 || axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL rm_reset_hs got=%b/%b exp=0/0", axi.axi_arready, axi.axi_rvalid); end
        total++; if (rd_addr !== 40'h0 || rd_prot !== 3'b000 || rd_req !== 1'b0) begin bad++; $display("FAIL rm_reset_fabric got=%h/%b/%b exp=0/0/0", rd_addr, rd_prot, rd_req); end
        tick();
        rd_ack = 1'b0;
        total++; if (axi.axi_arready !== 1'b1) begin bad++; $display("FAIL rm_arready got=%b exp=1", axi.axi_arready); end
        total++; if (axi.axi_rvalid !== 1'b0 || axi.axi_rdata !== 32'h0 || axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL rm_no_beat got=%b/%h/%b exp=0/0/00", axi.axi_rvalid, axi.axi_rdata, axi.axi_rresp); end
        tick();
        total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL rm_no_beat_later got=%b exp=0", axi.axi_rvalid); end
    endtask

    task automatic test_coincident();
        start_ar(40'h00_0000_0D00, 3'b000);
        for (int i = 0; i < 7; i++) tick();
        total++; if (axi.axi_rvalid !== 1'b0) begin bad++; $display("FAIL co_rvalid_early got=%b exp=0", axi.axi_rvalid); end
        rd_ack = 1'b1; rd_data = 32'hCAFE_F00D; rd_err = 1'b0;
        tick();
        rd_ack = 1'b0;
        total++; if (axi.axi_rvalid !== 1'b1) begin bad++; $display("FAIL co_rvalid got=%b exp=1", axi.axi_rvalid); end
        total++; if (axi.axi_rresp !== 2'b00) begin bad++; $display("FAIL co_rresp got=%b exp=00", axi.axi_rresp); end
        total++; if (axi.axi_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL co_rdata got=%h exp=cafef00d", axi.axi_rdata); end
        tick();
    endtask

    initial begin
        axi.axi_araddr  = '0;
        axi.axi_arprot  = '0;
        axi.axi_arvalid = 1'b0;
        axi.axi_rready  = 1'b1;
        test_reset();
        test_zero_latency();
        test_slverr();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_coincident();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
